instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the single-issue CPU. Holds the program counter, reads the instruction memory through a busywait handshake, and presents INSTRUCTION/PC to the decoder. Computes the next PC from the current instruction and the decoder's BRANCH/BRANCHNEQ/JUMP flags plus the ALU ZERO flag. Freezes while the data side reports busywait.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock. All state changes on the rising edge.
- RESET  in  1  reset, synchronous and active-low.
- BRANCH  in  1  decoder beq flag.
- BRANCHNEQ  in  1  decoder bne flag.
- JUMP  in  1  decoder jump flag.
- ZERO  in  1  ALU zero flag for the current instruction.
- STALL  in  1  data-memory busywait. High means hold the current instruction.
- IMEM_READ  out  1  instruction memory read request.
- IMEM_ADDRESS  out  32  byte address of the fetch, equal to PC.
- IMEM_READDATA  in  32  instruction word, valid when IMEM_BUSYWAIT is low.
- IMEM_BUSYWAIT  in  1  instruction memory not ready.
- INSTRUCTION  out  32  registered instruction sent to the decoder.
- PC  out  32  address of INSTRUCTION.
- INSTR_VALID  out  1  INSTRUCTION holds a fetched, executing instruction.

## Operation

- The FSM has three states: S_IDLE, S_REQ and S_EXEC.
- **S_IDLE**: entered on reset. IMEM_READ=0. Moves to S_REQ on the next edge.
- **S_REQ**: IMEM_READ=1 and IMEM_ADDRESS=PC.
  - On an edge with IMEM_BUSYWAIT=0: INSTRUCTION<=IMEM_READDATA, INSTR_VALID<=1, go to S_EXEC.
  - Otherwise stay, with PC and IMEM_ADDRESS stable.
- **S_EXEC**: IMEM_READ=0.
  - On an edge with STALL=1: hold everything.
  - On an edge with STALL=0: PC<=NEXT_PC, INSTR_VALID<=0, go to S_REQ.
- Flag qualification uses opcode = INSTRUCTION[31:24]. Flags are honoured only for these opcodes:
  - 8'h06 (j): take = JUMP.
  - 8'h07 (beq): take = BRANCH & ZERO.
  - 8'h0D (bne): take = BRANCHNEQ & ~ZERO.
  - Any other opcode: take = 0, whatever the flags are, including X.
- Next-PC arithmetic, all modulo 2^32 (wrap silently, no trap):
  - PC4 = PC + 4.
  - OFF = sign-extended INSTRUCTION[23:16], shifted left 2.
  - NEXT_PC = take ? PC4 + OFF : PC4.
- Reset values: PC=RESET_PC, INSTRUCTION=0, INSTR_VALID=0, state S_IDLE, IMEM_READ=0.
- RESET low at any edge overrides everything, including mid-busywait and mid-stall. An outstanding memory read is abandoned and the memory must tolerate READ dropping.

## Timing

- From reset release to the first IMEM_READ: 1 cycle (the S_IDLE edge).
- With zero-wait memory and no stall, one instruction completes every 2 cycles.
  - Edge 1 captures the instruction.
  - Edge 2 updates PC.
- Each cycle of IMEM_BUSYWAIT or STALL adds exactly one cycle.
- INSTRUCTION and PC change only on edges and stay constant for the whole S_EXEC residency. The decoder's internal delay must settle within one cycle.
- ZERO and the flags are sampled on the S_EXEC edge where STALL=0.
- IMEM_READ and IMEM_ADDRESS are decoded combinationally from state and PC registers only, with no input-to-output paths.

## Configuration

- CPU_FETCH_PERF_EN defined adds two outputs, both zeroed on reset and wrapping at 2^32:
  - INSTR_COUNT [31:0]: increments on each S_EXEC to S_REQ transition.
  - STALL_COUNT [31:0]: increments on each edge in S_REQ with IMEM_BUSYWAIT=1, or in S_EXEC with STALL=1.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Structure

- The shared package cpu_defs holds:
  - opcode constants OP_J=8'h06, OP_BEQ=8'h07, OP_BNE=8'h0D, used by the decoder and this block;
  - the fetch state encoding;
  - the default RESET_PC.
- One sub-module, fetch_next_pc: a combinational PC4/offset/target adder plus the take mux. Inputs are PC, INSTRUCTION, the flags and ZERO; output is NEXT_PC.
- The FSM and registers live in instruction_fetch.

## Test plan

- **Reset**: hold RESET=0 for 3 cycles, then release.
  - During reset: IMEM_READ=0, PC=0, INSTR_VALID=0.
  - IMEM_READ=1 with IMEM_ADDRESS=0 exactly one cycle after release.
- **Busywait**: IMEM_BUSYWAIT=1 for 3 cycles at PC=0, then 0 with READDATA=32'h0200_0102.
  - IMEM_ADDRESS stays 0 throughout.
  - INSTRUCTION=32'h0200_0102 on the next edge.
  - PC=4 one edge later.
- **beq**: PC=32'h10, INSTRUCTION=32'h07FE_0102, BRANCH=1.
  - ZERO=1: next PC=32'h0C.
  - ZERO=0: next PC=32'h14.
- **Flag qualification**:
  - INSTRUCTION=32'h11xx_xxxx with BRANCHNEQ=1, ZERO=0: PC advances by 4.
  - INSTRUCTION=32'h0D02_0304 with the same flags: PC = PC+4+8.
- **STALL in S_EXEC**: STALL=1 for 5 cycles.
  - PC, INSTRUCTION and INSTR_VALID=1 are held, and IMEM_READ=0.
  - PC advances on the first edge after STALL=0.
  - With CPU_FETCH_PERF_EN defined, STALL_COUNT=5.
- **Wrap and reset mid-busywait**:
  - PC=32'hFFFF_FFFC with a non-branch instruction: next PC=0.
  - RESET=0 during IMEM_BUSYWAIT: PC=RESET_PC and state S_IDLE on that edge.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared opcodes, fetch state encoding and default reset PC
package cpu_defs;
  localparam logic [7:0] OP_J = 8'h06;
  localparam logic [7:0] OP_BEQ = 8'h07;
  localparam logic [7:0] OP_BNE = 8'h0D;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC} fetch_state_t;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC adder with opcode-qualified take mux
module fetch_next_pc
  import cpu_defs::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] INSTRUCTION,
  input  logic        BRANCH,
  input  logic        BRANCHNEQ,
  input  logic        JUMP,
  input  logic        ZERO,
  output logic [31:0] NEXT_PC
);
  logic [7:0] opcode;
  logic take;
  logic [31:0] pc4;
  logic [31:0] off;
  logic unused_low;
  assign unused_low = ^INSTRUCTION[15:0];
  // Flags only count for j/beq/bne, so junk flags on other opcodes cannot redirect
  always_comb begin
    opcode = INSTRUCTION[31:24];
    take = (opcode == OP_J) ? JUMP :
           (opcode == OP_BEQ) ? (BRANCH & ZERO) :
           (opcode == OP_BNE) ? (BRANCHNEQ & ~ZERO) : 1'b0;
    pc4 = PC + 32'd4;
    off = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
    NEXT_PC = take ? pc4 + off : pc4;
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/IMEM handshake FSM; CPU_FETCH_PERF_EN adds perf counters
module instruction_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH,
  input  logic        BRANCHNEQ,
  input  logic        JUMP,
  input  logic        ZERO,
  input  logic        STALL,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic        INSTR_VALID
`ifdef CPU_FETCH_PERF_EN
  ,
  output logic [31:0] INSTR_COUNT,
  output logic [31:0] STALL_COUNT
`endif
);
  fetch_state_t state, state_next;
  logic [31:0] next_pc;
  logic fetch_done, exec_done;

  fetch_next_pc u_next_pc (
    .PC(PC),
    .INSTRUCTION(INSTRUCTION),
    .BRANCH(BRANCH),
    .BRANCHNEQ(BRANCHNEQ),
    .JUMP(JUMP),
    .ZERO(ZERO),
    .NEXT_PC(next_pc)
  );

  assign fetch_done = (state == S_REQ) && !IMEM_BUSYWAIT;
  assign exec_done = (state == S_EXEC) && !STALL;

  // State register; reset abandons any outstanding read
  always_ff @(posedge CLK)
    state <= !RESET ? S_IDLE : state_next;

  // Next state and memory request, decoded from state/PC only
  always_comb begin
    state_next = state;
    state_next = (state == S_IDLE) ? S_REQ :
                 (state == S_REQ) ? (IMEM_BUSYWAIT ? S_REQ : S_EXEC) :
                 (state == S_EXEC) ? (STALL ? S_EXEC : S_REQ) : S_IDLE;
    IMEM_READ = (state == S_REQ);
    IMEM_ADDRESS = PC;
  end

  // Capture the instruction on fetch, advance PC when execution leaves
  always_ff @(posedge CLK)
    if (!RESET) begin
      PC <= RESET_PC;
      INSTRUCTION <= '0;
      INSTR_VALID <= 1'b0;
    end else begin
      if (fetch_done) begin
        INSTRUCTION <= IMEM_READDATA;
        INSTR_VALID <= 1'b1;
      end
      if (exec_done) begin
        PC <= next_pc;
        INSTR_VALID <= 1'b0;
      end
    end

`ifdef CPU_FETCH_PERF_EN
  // Count completed instructions and every cycle lost to busywait or stall
  always_ff @(posedge CLK)
    if (!RESET) begin
      INSTR_COUNT <= '0;
      STALL_COUNT <= '0;
    end else begin
      if (exec_done) INSTR_COUNT <= INSTR_COUNT + 32'd1;
      if ((state == S_REQ && IMEM_BUSYWAIT) || (state == S_EXEC && STALL))
        STALL_COUNT <= STALL_COUNT + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random checks of instruction_fetch against a transaction model
module tb_instruction_fetch;
  logic CLK = 1'b0;
  logic RESET, BRANCH, BRANCHNEQ, JUMP, ZERO, STALL, IMEM_BUSYWAIT;
  logic IMEM_READ, INSTR_VALID;
  logic [31:0] IMEM_ADDRESS, IMEM_READDATA, INSTRUCTION, PC;
`ifdef CPU_FETCH_PERF_EN
  logic [31:0] INSTR_COUNT, STALL_COUNT;
  int exp_instr_cnt, exp_stall_cnt;
`endif
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;

  instruction_fetch dut (
    .CLK(CLK),
    .RESET(RESET),
    .BRANCH(BRANCH),
    .BRANCHNEQ(BRANCHNEQ),
    .JUMP(JUMP),
    .ZERO(ZERO),
    .STALL(STALL),
    .IMEM_READ(IMEM_READ),
    .IMEM_ADDRESS(IMEM_ADDRESS),
    .IMEM_READDATA(IMEM_READDATA),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .INSTRUCTION(INSTRUCTION),
    .PC(PC),
    .INSTR_VALID(INSTR_VALID)
`ifdef CPU_FETCH_PERF_EN
    ,
    .INSTR_COUNT(INSTR_COUNT),
    .STALL_COUNT(STALL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input bit br, input bit bne, input bit jmp, input bit z);
    int op;
    bit take;
    int disp;
    op = int'(instr[31:24]);
    take = (op == 6) ? jmp : (op == 7) ? (br && z) : (op == 13) ? (bne && !z) : 1'b0;
    disp = int'($signed(instr[23:16])) * 4;
    return pc + 32'd4 + (take ? 32'(disp) : 32'd0);
  endfunction

  // One instruction: bw busywait cycles, capture, st stall cycles, then PC update
  task automatic fetch_exec(input logic [31:0] instr, input int bw, input int st,
                            input bit br, input bit bne, input bit jmp, input bit z);
    for (int i = 0; i < bw; i++) begin
      check("req_read", IMEM_READ, 1'b1);
      check("req_addr", IMEM_ADDRESS, exp_pc);
      IMEM_BUSYWAIT = 1'b1;
      IMEM_READDATA = $urandom;
      STALL = 1'($urandom);
      tick;
    end
    check("req_read", IMEM_READ, 1'b1);
    check("req_addr", IMEM_ADDRESS, exp_pc);
    IMEM_BUSYWAIT = 1'b0;
    IMEM_READDATA = instr;
    STALL = 1'($urandom);
    tick;
    IMEM_READDATA = $urandom;
    check("cap_instr", INSTRUCTION, instr);
    check("cap_pc", PC, exp_pc);
    check("cap_valid", INSTR_VALID, 1'b1);
    check("cap_read", IMEM_READ, 1'b0);
    for (int i = 0; i < st; i++) begin
      STALL = 1'b1;
      IMEM_BUSYWAIT = 1'($urandom);
      {BRANCH, BRANCHNEQ, JUMP, ZERO} = 4'($urandom);
      tick;
      check("stall_pc", PC, exp_pc);
      check("stall_instr", INSTRUCTION, instr);
      check("stall_valid", INSTR_VALID, 1'b1);
      check("stall_read", IMEM_READ, 1'b0);
    end
    STALL = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    BRANCH = br;
    BRANCHNEQ = bne;
    JUMP = jmp;
    ZERO = z;
    tick;
    exp_pc = model_next(exp_pc, instr, br, bne, jmp, z);
    {BRANCH, BRANCHNEQ, JUMP, ZERO} = 4'($urandom);
    check("next_pc", PC, exp_pc);
    check("next_valid", INSTR_VALID, 1'b0);
    check("next_read", IMEM_READ, 1'b1);
`ifdef CPU_FETCH_PERF_EN
    exp_stall_cnt += bw + st;
    exp_instr_cnt += 1;
    check("instr_count", INSTR_COUNT, 32'(exp_instr_cnt));
    check("stall_count", STALL_COUNT, 32'(exp_stall_cnt));
`endif
  endtask

  task automatic do_reset;
    RESET = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    STALL = 1'b0;
    repeat (3) begin
      tick;
      check("rst_read", IMEM_READ, 1'b0);
      check("rst_pc", PC, 32'h0);
      check("rst_valid", INSTR_VALID, 1'b0);
      check("rst_instr", INSTRUCTION, 32'h0);
    end
    RESET = 1'b1;
    check("idle_read", IMEM_READ, 1'b0);
    tick;
    check("first_read", IMEM_READ, 1'b1);
    check("first_addr", IMEM_ADDRESS, 32'h0);
    exp_pc = 32'h0;
`ifdef CPU_FETCH_PERF_EN
    exp_instr_cnt = 0;
    exp_stall_cnt = 0;
    check("rst_icount", INSTR_COUNT, 32'h0);
    check("rst_scount", STALL_COUNT, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] instr;
    logic [7:0] op;
    RESET = 1'b0;
    BRANCH = 1'b0;
    BRANCHNEQ = 1'b0;
    JUMP = 1'b0;
    ZERO = 1'b0;
    STALL = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    IMEM_READDATA = 32'h0;
    do_reset;
    fetch_exec(32'h0200_0102, 3, 0, 0, 0, 0, 0);
    check("busywait_pc4", PC, 32'h4);
    repeat (3) fetch_exec(32'h0100_0000, 0, 0, 1, 1, 1, 0);
    check("at_10", PC, 32'h10);
    fetch_exec(32'h07FE_0102, 0, 0, 1, 0, 0, 1);
    check("beq_taken", PC, 32'h0C);
    fetch_exec(32'h0100_0000, 0, 0, 0, 0, 0, 0);
    fetch_exec(32'h07FE_0102, 0, 0, 1, 0, 0, 0);
    check("beq_not_taken", PC, 32'h14);
    fetch_exec(32'h11AB_CDEF, 0, 0, 1, 1, 1, 0);
    check("qual_other", PC, 32'h18);
    fetch_exec(32'h0D02_0304, 0, 0, 0, 1, 0, 0);
    check("bne_taken", PC, 32'h24);
`ifdef CPU_FETCH_PERF_EN
    exp_stall_cnt = int'(STALL_COUNT);
`endif
    fetch_exec(32'h0300_0000, 0, 5, 0, 0, 0, 0);
    check("stall_release_pc", PC, 32'h28);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h06;
        1: op = 8'h07;
        2: op = 8'h0D;
        default: op = 8'($urandom);
      endcase
      instr = {op, 24'($urandom)};
      fetch_exec(instr, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    IMEM_BUSYWAIT = 1'b1;
    tick;
    tick;
    check("bw_hold_addr", IMEM_ADDRESS, exp_pc);
    RESET = 1'b0;
    tick;
    check("midbw_rst_pc", PC, 32'h0);
    check("midbw_rst_read", IMEM_READ, 1'b0);
    check("midbw_rst_valid", INSTR_VALID, 1'b0);
`ifdef CPU_FETCH_PERF_EN
    check("midbw_rst_scount", STALL_COUNT, 32'h0);
`endif
    do_reset;
    fetch_exec(32'h06FE_0000, 0, 0, 0, 0, 1, 0);
    check("jump_back", PC, 32'hFFFF_FFFC);
    fetch_exec(32'h0100_0000, 1, 0, 1, 1, 1, 1);
    check("wrap_pc", PC, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
